// File: rtl/clk_pkg.sv
// Shared constants for the programmable clock divider: default geometry and
// the smallest period that still yields a two-phase output.
package clk_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 100;
  localparam int MIN_DIV   = 2;

endpackage

// File: rtl/div_load_ctrl.sv
// Period load handshake: holds one pending period, drives div_ready/div_err and
// tells the counter when the pending value may replace the active period.
module div_load_ctrl
  import clk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  input  logic             apply_ok,
  output logic             div_ready,
  output logic             div_err,
  output logic             load,
  output logic [WIDTH-1:0] pend
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_DIV);

  logic pend_vld;
  logic hs;
  logic accept;
  logic reject;

  assign hs     = div_valid && div_ready;
  assign accept = hs && (div_in >= MIN_P);
  assign reject = hs && (div_in < MIN_P);

  // A value accepted on this edge is never applied on the same edge: pend_vld
  // is still clear, so load cannot fire until a later qualifying edge.
  assign load = pend_vld && apply_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend      <= '0;
      div_ready <= 1'b1;
      div_err   <= 1'b0;
    end else begin
      div_err <= reject;
      if (load) begin
        pend_vld  <= 1'b0;
        div_ready <= 1'b1;
      end else if (accept) begin
        pend      <= div_in;
        pend_vld  <= 1'b1;
        div_ready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider: tick strobe once per period P and a square wave
// low for floor(P/2) cycles, high for ceil(P/2); P reloadable via handshake.
module clock_div_prog
  import clk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] pend;
  logic             wrap;
  logic             apply_ok;
  logic             load;

  assign half = p >> 1;

  // ">=" rather than "==": a shorter period applied while disabled can leave
  // cnt beyond the new end, and the next enabled edge must still wrap.
  assign wrap     = en && !sync && (cnt >= p - WIDTH'(1));
  assign apply_ok = sync || !en || wrap;

  always_comb begin
    cnt_next = cnt;
    if (sync) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = wrap ? '0 : cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= DEF_P;
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= wrap;
      if (sync) begin
        clk_out <= 1'b0;
      end else if (en) begin
        clk_out <= (cnt_next >= half);
      end
      if (load) begin
        p <= pend;
      end
    end
  end

  div_load_ctrl #(
    .WIDTH(WIDTH)
  ) u_load (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .div_valid(div_valid),
    .apply_ok (apply_ok),
    .div_ready(div_ready),
    .div_err  (div_err),
    .load     (load),
    .pend     (pend)
  );

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog: a phase/period model predicts outputs per
// edge into a queue; a negedge monitor pops and compares.
module tb_clock_div_prog;

  localparam int W  = 16;
  localparam int DD = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync = 1'b0;
  logic         div_valid = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         div_ready;
  logic         div_err;
  logic         tick;
  logic         clk_out;

  clock_div_prog #(.WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_in   (div_in),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .div_err  (div_err),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tick;
    logic clk_out;
    logic div_ready;
    logic div_err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int tick_seen = 0;

  // Reference model: phase within the period, active period, pending period (-1 = none)
  int m_period, m_phase, m_pend, m_ready, m_clk, m_tick, m_err;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_n, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tick", tick, e.tick);
      check("clk_out", clk_out, e.clk_out);
      check("div_ready", div_ready, e.div_ready);
      check("div_err", div_err, e.div_err);
      if (tick === 1'b1) tick_seen++;
    end
  end

  task automatic model_reset();
    m_period = DD;
    m_phase  = 0;
    m_pend   = -1;
    m_ready  = 1;
    m_clk    = 0;
    m_tick   = 0;
    m_err    = 0;
  endtask

  task automatic model_edge();
    int  din;
    bit  hs, wrap, apply;
    din   = int'(div_in);
    hs    = div_valid && (m_ready != 0);
    wrap  = en && !sync && (m_phase >= m_period - 1);
    apply = (m_pend >= 0) && (sync || !en || wrap);
    m_err  = (hs && din < 2) ? 1 : 0;
    m_tick = wrap ? 1 : 0;
    if (sync) begin
      m_phase = 0;
      m_clk   = 0;
    end else if (en) begin
      m_phase = wrap ? 0 : m_phase + 1;
      m_clk   = (m_phase >= m_period / 2) ? 1 : 0;
    end
    if (apply) begin
      m_period = m_pend;
      m_pend   = -1;
      m_ready  = 1;
    end else if (hs && din >= 2) begin
      m_pend  = din;
      m_ready = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    edge_n++;
    e.tick      = (m_tick != 0);
    e.clk_out   = (m_clk != 0);
    e.div_ready = (m_ready != 0);
    e.div_err   = (m_err != 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int v);
    div_valid = 1'b1;
    div_in    = W'(v);
    step();
    div_valid = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    for (int k = 0; k < 400 && m_phase != ph; k++) step();
    check_int("reach_phase", m_phase, ph);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("rst_tick", tick, 1'b0);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_div_ready", div_ready, 1'b1);
    check("rst_div_err", div_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    reset_pulse();

    // Default period: ticks at edges 100, 200, 300
    en = 1'b1;
    tick_seen = 0;
    run(300);
    drain();
    check_int("default_ticks", tick_seen, 3);

    // Load 5 at cnt=20; pending until the wrap at edge 100
    run(20);
    load(5);
    run(79);
    tick_seen = 0;
    run(26);
    drain();
    check_int("p5_ticks", tick_seen, 6);

    // Illegal periods rejected
    load(1);
    load(0);
    run(10);

    // P=10 with sync mid-period and sync on the wrap cycle
    load(10);
    en = 1'b0;
    step();
    en = 1'b1;
    run_to_phase(7);
    sync = 1'b1; step(); sync = 1'b0;
    run(15);
    run_to_phase(9);
    sync = 1'b1; step(); sync = 1'b0;
    run(12);

    // P=8 with a 3-cycle enable gap, then a load while disabled
    load(8);
    run(10);
    run_to_phase(3);
    en = 1'b0; run(3); en = 1'b1;
    run(12);
    en = 1'b0;
    load(6);
    step();
    en = 1'b1;
    run(20);

    // Reset mid-period with a pending load of 7
    reset_pulse();
    run(40);
    load(7);
    run(3);
    reset_pulse();
    tick_seen = 0;
    run(210);
    drain();
    check_int("post_reset_ticks", tick_seen, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      sync      = ($urandom_range(0, 29) == 0);
      div_valid = ($urandom_range(0, 7) == 0);
      div_in    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(2, 14));
      step();
      if (i == 1500) reset_pulse();
    end
    en = 1'b1; sync = 1'b0; div_valid = 1'b0;
    run(5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of the period and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 100, giving the period P loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port sync, input, 1 bit: single-cycle phase restart request.
REQ-007 SHALL have port div_in, input, WIDTH bits: requested new period P.
REQ-008 SHALL have port div_valid, input, 1 bit: div_in is valid.
REQ-009 SHALL have port div_ready, output, 1 bit: ready to accept div_in.
REQ-010 SHALL have port div_err, output, 1 bit: one-cycle pulse on rejected div_in.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle strobe once per period.
REQ-012 SHALL have port clk_out, output, 1 bit: divided square wave.

Function
REQ-013 SHALL hold the active period P, an optional pending period, and counter cnt (0..P-1); all outputs registered.
REQ-014 SHALL, on each clk edge with en=1 and sync=0: if cnt==P-1, set cnt to 0 and tick to 1 (period wrap); else increment cnt and set tick to 0.
REQ-015 SHALL drive clk_out from the next cnt value: 0 while cnt_next < floor(P/2), else 1; low floor(P/2) cycles, high ceil(P/2) cycles.
REQ-016 SHALL, with en=0, hold cnt and clk_out and drive tick 0.
REQ-017 SHALL, on sync=1, set cnt to 0, clk_out to 0 and tick to 0 regardless of en; sync has priority over wrap.
REQ-018 SHALL accept div_in on the edge where div_valid and div_ready are both 1 and 2 <= div_in.
REQ-019 SHALL store an accepted value as pending and deassert div_ready until that value is applied.
REQ-020 SHALL apply pending to P on the next wrap edge, sync edge, or any edge with en=0, then reassert div_ready on the following cycle.
REQ-021 SHALL, when the pending value is applied at a wrap edge, generate the next period with the new P; the wrap tick itself is unaffected.
REQ-022 SHALL, when div_valid=1, div_ready=1 and div_in<2, pulse div_err for one cycle, discard the value and keep div_ready=1.
REQ-023 SHALL, if accept and apply conditions coincide on the same edge, latch to pending only; apply on a later qualifying edge.
REQ-024 SHALL treat div_in == P as a legal load with identical handshake.
REQ-025 SHALL hold div_ready low while no handshake is possible; div_valid without ready SHALL have no effect.

Reset
REQ-026 SHALL on rst=1 asynchronously set P=DEFAULT_DIV, clear pending, cnt=0, tick=0, clk_out=0, div_err=0, div_ready=1.
REQ-027 SHALL, on reset asserted mid-period or with a pending value, discard all state; the first tick after release SHALL come after DEFAULT_DIV enabled edges.

Structure
REQ-028 SHALL place DEFAULT_DIV default, WIDTH default and minimum legal period constant (2) in a shared package clk_pkg.
REQ-029 SHALL implement the period load handshake in one sub-module div_load_ctrl (pending register, div_ready, div_err); counter logic stays in the top.

Verification
REQ-030 Reset, en=1 held, DEFAULT_DIV=100 -> tick pulses at edges 100, 200, 300; clk_out low 50, high 50 cycles.
REQ-031 Load div_in=5 at cnt=20 of P=100 -> div_ready low until wrap at edge 100; then ticks every 5 cycles; clk_out low 2, high 3.
REQ-032 div_in=1 and div_in=0 with div_valid -> div_err pulses one cycle each; P unchanged; div_ready stays 1.
REQ-033 P=10, sync at cnt=7 -> cnt=0, clk_out=0, no tick; next tick 10 enabled edges after sync; sync coincident with cnt=9 -> no tick.
REQ-034 P=8, en low for 3 cycles mid-period -> cnt, clk_out frozen, tick 0; period stretched to 11 cycles; load while en=0 -> applied next edge.
REQ-035 Assert rst at cnt=40 with pending load of 7 -> all outputs reset values; after release, tick period is 100, not 7.
